// File: rtl/cru_pkg.sv
// Shared CRU bus definitions: op encodings, address width and initiator states.
// Also used by the peripheral-side CRU decoder.
package cru_pkg;

    localparam int CRU_ADDR_W = 12;

    localparam logic [1:0] CRU_SBZ  = 2'b00;
    localparam logic [1:0] CRU_SBO  = 2'b01;
    localparam logic [1:0] CRU_LDCR = 2'b10;
    localparam logic [1:0] CRU_STCR = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Level driven on CRUOUT for the bit currently on the bus.
    function automatic logic cru_out_bit(input logic [1:0] op, input logic data_bit);
        case (op)
            CRU_SBO:  return 1'b1;
            CRU_LDCR: return data_bit;
            default:  return 1'b0;
        endcase
    endfunction

    // Bits moved by one command; single-bit ops ignore the count, and 0 means 16.
    function automatic logic [4:0] cru_bit_count(input logic [1:0] op, input logic [3:0] count);
        if (op == CRU_SBZ || op == CRU_SBO) return 5'd1;
        if (count == 4'd0)                  return 5'd16;
        return {1'b0, count};
    endfunction

endpackage

// File: rtl/cru_phase_timer.sv
// Loadable down-counter timing one SETUP or PULSE phase of CLK_DIV cycles.
// phase_done is high in the last cycle of the phase.
module cru_phase_timer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic phase_done
);

    localparam logic [3:0] LOAD_VAL = 4'(CLK_DIV - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    assign phase_done = (cnt_q == 4'd0);

    // NOTE: flops take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cru_master.sv
// CRU bus initiator: runs SBZ/SBO/LDCR/STCR commands as serial CRU bus cycles
// and returns sampled CRUIN data on a one-cycle completion pulse.
module cru_master
    import cru_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [CRU_ADDR_W-1:0] cmd_addr,
    input  logic [3:0]            cmd_count,
    input  logic [15:0]           cmd_data,
    output logic                  rsp_valid,
    output logic [15:0]           rsp_data,
    output logic [CRU_ADDR_W-1:0] cru_address,
    output logic                  cruout,
    output logic                  cruclk,
    input  logic                  cruin
);

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [15:0]           data_q, data_d;
    logic [15:0]           in_q, in_d;
    logic [CRU_ADDR_W-1:0] cru_address_q, cru_address_d;
    logic                  cruout_q, cruout_d;
    logic                  cruclk_q, cruclk_d;
    logic                  phase_done;
    logic                  timer_load;

    // The timer is parked loaded outside SETUP/PULSE and reloads at each phase end.
    assign timer_load = (state_q != ST_SETUP && state_q != ST_PULSE) || phase_done;

    cru_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .phase_done (phase_done)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        data_d        = data_q;
        in_d          = in_q;
        cru_address_d = cru_address_q;
        cruout_d      = cruout_q;
        cruclk_d      = cruclk_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d          = cmd_op;
                    cnt_d         = cru_bit_count(cmd_op, cmd_count);
                    idx_d         = 4'd0;
                    data_d        = cmd_data;
                    in_d          = 16'd0;
                    cru_address_d = cmd_addr;
                    cruout_d      = cru_out_bit(cmd_op, cmd_data[0]);
                    state_d       = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (phase_done) begin
                    if (op_q == CRU_STCR) begin
                        in_d[idx_q] = cruin;
                        state_d     = ST_HOLD;
                    end else begin
                        cruclk_d = 1'b1;
                        state_d  = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                if (phase_done) begin
                    cruclk_d = 1'b0;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The bus keeps the last bit's address and level once the count runs out.
                if (cnt_q == 5'd1) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d         = cnt_q - 5'd1;
                    idx_d         = idx_q + 4'd1;
                    data_d        = data_q >> 1;
                    cru_address_d = cru_address_q + 12'd1;
                    cruout_d      = cru_out_bit(op_q, data_q[1]);
                    state_d       = ST_SETUP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= CRU_SBZ;
            cnt_q         <= 5'd0;
            idx_q         <= 4'd0;
            data_q        <= 16'd0;
            in_q          <= 16'd0;
            cru_address_q <= '0;
            cruout_q      <= 1'b0;
            cruclk_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            in_q          <= in_d;
            cru_address_q <= cru_address_d;
            cruout_q      <= cruout_d;
            cruclk_q      <= cruclk_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_DONE);
    assign rsp_data    = (state_q == ST_DONE) ? in_q : 16'd0;
    assign cru_address = cru_address_q;
    assign cruout      = cruout_q;
    assign cruclk      = cruclk_q;

endmodule

// File: tb/tb_cru_master.sv
// Scoreboard bench for cru_master: the driver pushes expected responses and bus strobes,
// and independent monitors pop and compare them against what the DUT presents.
module tb_cru_master;
    import cru_pkg::*;

    localparam int D = 4;

    typedef struct {
        logic [15:0] data;
        int          lat;
        int          acc;
    } rsp_exp_t;

    typedef struct {
        logic [11:0] addr;
        logic        bit_v;
        int          rel;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [3:0]  cmd_count;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [11:0] cru_address;
    logic        cruout, cruclk, cruin;

    rsp_exp_t    rsp_q[$];
    bus_exp_t    bus_q[$];
    rsp_exp_t    rsp_e;
    bus_exp_t    bus_e;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cur_acc = 0;
    int          rises = 0;
    int          last_acc = 0;
    int          last_lat = 0;
    bit          last_keep = 1'b0;
    bit          use_lsb = 1'b0;
    logic        pat [4096];

    logic        prev_clk = 1'b0;
    logic [11:0] hi_addr;
    logic        hi_out;
    int          width = 0;
    bit          stable = 1'b1;

    cru_master #(.CLK_DIV(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_count   (cmd_count),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .cru_address (cru_address),
        .cruout      (cruout),
        .cruclk      (cruclk),
        .cruin       (cruin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral side: each CRU address reads back a fixed bit of a random map.
    assign cruin = use_lsb ? cru_address[0] : pat[cru_address];

    function automatic logic src_bit(input logic [11:0] a);
        return use_lsb ? a[0] : pat[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one command; the model derives response, latency and bus strobes from the op rules.
    task automatic send(input logic [1:0] op, input logic [11:0] addr, input logic [3:0] count,
                        input logic [15:0] data, input bit keep, input bit abort);
        int          n;
        int          lat;
        int          acc;
        int          waits;
        logic [15:0] exp;
        bus_exp_t    be;
        @(negedge clk);
        cmd_valid = 1'b1;
        waits = 0;
        while (!cmd_ready) begin
            cmd_op    = 2'($urandom);
            cmd_addr  = 12'($urandom);
            cmd_count = 4'($urandom);
            cmd_data  = 16'($urandom);
            @(negedge clk);
            waits++;
            if (waits > 400) begin
                check("accept_timeout", 32'(waits), 32'd0);
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_count = count;
        cmd_data  = data;
        acc = cyc + 1;
        if (last_keep) check("b2b_accept_edge", 32'(acc), 32'(last_acc + last_lat + 1));
        n = (op == CRU_SBZ || op == CRU_SBO) ? 1 : ((count == 4'd0) ? 16 : int'(count));
        exp = 16'd0;
        if (op == CRU_STCR) begin
            for (int i = 0; i < n; i++) exp[i] = src_bit(addr + 12'(i));
            lat = n * (D + 1) + 1;
        end else begin
            lat = n * (2 * D + 1) + 1;
            for (int i = 0; i < n; i++) begin
                if (!abort || i < 2) begin
                    be.addr  = addr + 12'(i);
                    be.bit_v = (op == CRU_LDCR) ? data[i] : (op == CRU_SBO);
                    be.rel   = i * (2 * D + 1) + D + 1;
                    bus_q.push_back(be);
                end
            end
        end
        if (!abort) rsp_q.push_back('{exp, lat, acc});
        cur_acc   = acc;
        last_acc  = acc;
        last_lat  = lat;
        last_keep = keep && !abort;
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while ((rsp_q.size() != 0 || !cmd_ready) && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        check("drain_in_time", 32'(waits < 1000), 32'd1);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) begin
                rsp_e = rsp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(rsp_e.data));
                check("rsp_cycle", 32'(cyc - rsp_e.acc + 1), 32'(rsp_e.lat));
            end
        end
    end

    // Bus monitor: strobe position, address/level, width and stability while high.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_clk = 1'b0;
            width    = 0;
        end else begin
            if (cruclk && !prev_clk) begin
                rises++;
                check("bus_expected", 32'(bus_q.size() != 0), 32'd1);
                if (bus_q.size() != 0) begin
                    bus_e = bus_q.pop_front();
                    check("bus_addr", 32'(cru_address), 32'(bus_e.addr));
                    check("bus_cruout", 32'(cruout), 32'(bus_e.bit_v));
                    check("bus_rise_cycle", 32'(cyc - cur_acc + 1), 32'(bus_e.rel));
                end
                hi_addr = cru_address;
                hi_out  = cruout;
                width   = 1;
                stable  = 1'b1;
            end else if (cruclk && prev_clk) begin
                width++;
                if (cru_address != hi_addr || cruout != hi_out) stable = 1'b0;
            end else if (!cruclk && prev_clk) begin
                check("cruclk_width", 32'(width), 32'(D));
                check("bus_stable_high", 32'(stable), 32'd1);
            end
            prev_clk = cruclk;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run did not complete (checks %0d)", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int w;
        bit keep;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 12'd0;
        cmd_count = 4'd0;
        cmd_data  = 16'd0;
        for (int i = 0; i < 4096; i++) pat[i] = 1'($urandom);
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_cru_address", 32'(cru_address), 32'd0);
        check("reset_cruout", 32'(cruout), 32'd0);
        check("reset_cruclk", 32'(cruclk), 32'd0);
        rst_n = 1'b1;

        // SBO to the SAMS card select.
        send(CRU_SBO, 12'hF00, 4'd0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check("sbo_addr_cycle1", 32'(cru_address), 32'h0F00);
        check("sbo_cruout_cycle1", 32'(cruout), 32'd1);
        drain();

        r0 = rises;
        send(CRU_LDCR, 12'h980, 4'd8, 16'h00A5, 1'b0, 1'b0);
        drain();
        check("ldcr8_pulse_count", 32'(rises - r0), 32'd8);

        use_lsb = 1'b1;
        r0 = rises;
        send(CRU_STCR, 12'h100, 4'd0, 16'hFFFF, 1'b0, 1'b0);
        drain();
        check("stcr_no_cruclk", 32'(rises - r0), 32'd0);
        use_lsb = 1'b0;

        send(CRU_LDCR, 12'hFFE, 4'd3, 16'h0005, 1'b0, 1'b0);
        drain();

        // Reset in the middle of the second strobe of an LDCR.
        r0 = rises;
        send(CRU_LDCR, 12'h123, 4'd6, 16'h5A3C, 1'b0, 1'b1);
        w = 0;
        while (rises < r0 + 2 && w < 400) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("second_pulse_seen", 32'(rises - r0), 32'd2);
        check("pre_reset_cruclk", 32'(cruclk), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_cruclk", 32'(cruclk), 32'd0);
        check("async_cru_address", 32'(cru_address), 32'd0);
        check("async_cruout", 32'(cruout), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rsp_data", 32'(rsp_data), 32'd0);
        check("async_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_bus_queue_empty", 32'(bus_q.size()), 32'd0);
        send(CRU_SBZ, 12'h880, 4'd7, 16'hFFFF, 1'b0, 1'b0);
        drain();

        // Back-to-back with cmd_valid held high and inputs churning while busy.
        send(CRU_SBO, 12'h1A0, 4'd0, 16'h0000, 1'b1, 1'b0);
        send(CRU_LDCR, 12'h1A4, 4'd5, 16'h0013, 1'b1, 1'b0);
        send(CRU_STCR, 12'h2F0, 4'd4, 16'h0000, 1'b0, 1'b0);
        drain();

        for (int k = 0; k < 40; k++) begin
            keep = ($urandom_range(0, 3) == 0) && (k != 39);
            send(2'($urandom), 12'($urandom), 4'($urandom), 16'($urandom), keep, 1'b0);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        check("final_bus_queue_empty", 32'(bus_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
